// File: rtl/hdr_pkg.sv
// Shared types and default constants for the HDR sequencer and its sub-engines.
package hdr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CCC   = 3'd1,
        ST_DUMMY = 3'd2,
        ST_XFER  = 3'd3,
        ST_DONE  = 3'd4
    } hdr_state_e;

    localparam logic [2:0] HDR_MODE_ACTIVE    = 3'd6;
    localparam logic [7:0] IDLE_ADDR_DEFAULT  = 8'h10;
    localparam logic [7:0] DUMMY_ADDR_DEFAULT = 8'h84;

    // States in which a sub-engine or the CCC engine owns the bus and the watchdog runs.
    function automatic logic is_phase(input hdr_state_e s);
        return (s == ST_CCC) || (s == ST_DUMMY) || (s == ST_XFER);
    endfunction

endpackage

// File: rtl/hdr_watchdog.sv
// Loadable saturating down-counter; flags expiry when it sits at zero while enabled.
module hdr_watchdog #(
    parameter int TMO_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [TMO_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    logic [TMO_W-1:0] r_cnt;

    // Reload on phase entry, otherwise count down and hold at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = i_en && (r_cnt == '0);

endmodule

// File: rtl/hdr_engine_seq.sv
// HDR-mode sequencer: chains CCC and normal transfers under TOC control,
// with a dummy-CCC fetch on CCC->transfer restarts, per-phase watchdog and mode abort.
//
// state | meaning
// IDLE  | waiting for engine enable
// CCC   | CCC engine running
// DUMMY | CCC engine fetching the dummy value from DUMMY_ADDR
// XFER  | selected sub-engine running
// DONE  | run finished; completion pulse follows
module hdr_engine_seq
    import hdr_pkg::*;
#(
    parameter int                NUM_MODES     = 2,
    parameter int                SEL_W         = 1,
    parameter int                ADDR_W        = 8,
    parameter logic [ADDR_W-1:0] IDLE_ADDR     = ADDR_W'(IDLE_ADDR_DEFAULT),
    parameter logic [ADDR_W-1:0] DUMMY_ADDR    = ADDR_W'(DUMMY_ADDR_DEFAULT),
    parameter logic [2:0]        HDR_MODE_CODE = HDR_MODE_ACTIVE,
    parameter int                TMO_W         = 16,
    parameter logic [TMO_W-1:0]  TMO_CYCLES    = TMO_W'(50000)
) (
    input  logic                 i_sys_clk,
    input  logic                 i_sys_rst,
    input  logic                 i_i3cengine_hdrengine_en,
    input  logic                 i_CP,
    input  logic                 i_TOC,
    input  logic [2:0]           i_MODE,
    input  logic [SEL_W-1:0]     i_hdr_sel,
    input  logic                 i_ccc_done,
    input  logic [NUM_MODES-1:0] i_xfer_done,
    output logic                 o_ccc_en,
    output logic [NUM_MODES-1:0] o_xfer_en,
    output logic [ADDR_W-1:0]    o_regf_addr_special,
    output logic                 o_i3cengine_hdrengine_done,
    output logic                 o_error,
    output logic                 o_busy
);

    hdr_state_e           r_state, w_state_nxt;
    logic [SEL_W-1:0]     r_sel, w_sel_nxt;
    logic                 r_ccc_en, r_done, r_error, r_busy;
    logic [NUM_MODES-1:0] r_xfer_en, w_xfer_oh;
    logic [ADDR_W-1:0]    r_addr;
    logic w_sel_ld, w_sel_bad, w_err_set, w_err_clr, w_rearm;
    logic w_wd_ld, w_wd_en, w_wd_exp, w_mode_bad, w_ccc_done_ok, w_xfer_done_ok;

    // Strobes only count while the matching enable is actually driven,
    // which also masks them during the one-cycle re-arm gap.
    assign w_ccc_done_ok  = i_ccc_done && r_ccc_en;
    assign w_xfer_done_ok = |(i_xfer_done & r_xfer_en);
    assign w_mode_bad     = (i_MODE != HDR_MODE_CODE);
    assign w_sel_bad      = ({{(32-SEL_W){1'b0}}, i_hdr_sel} >= 32'(NUM_MODES));
    assign w_sel_nxt      = w_sel_ld ? i_hdr_sel : r_sel;
    assign w_xfer_oh      = NUM_MODES'(1) << w_sel_nxt;
    assign w_wd_en        = is_phase(r_state);

    hdr_watchdog #(.TMO_W(TMO_W)) u_watchdog (
        .i_clk      (i_sys_clk),
        .i_rst      (i_sys_rst),
        .i_load     (w_wd_ld),
        .i_load_val (TMO_CYCLES - TMO_W'(1)),
        .i_en       (w_wd_en),
        .o_expired  (w_wd_exp)
    );

    // Next-state decode; priority: enable drop > mode abort > done strobe > timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_ld    = 1'b0;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;
        w_rearm     = 1'b0;
        if (!i_i3cengine_hdrengine_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_err_clr = 1'b1;
                    if (i_CP) begin
                        w_state_nxt = ST_CCC;
                    end else begin
                        w_sel_ld = 1'b1;
                        if (w_sel_bad) begin
                            w_state_nxt = ST_DONE;
                            w_err_set   = 1'b1;
                        end else begin
                            w_state_nxt = ST_XFER;
                        end
                    end
                end
                ST_CCC: begin
                    if (w_mode_bad) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_ccc_done_ok) begin
                        if (i_TOC) begin
                            w_state_nxt = ST_DONE;
                        end else if (i_CP) begin
                            w_state_nxt = ST_CCC;
                            w_rearm     = 1'b1;
                        end else begin
                            w_state_nxt = ST_DUMMY;
                        end
                    end else if (w_wd_exp) begin
                        w_state_nxt = ST_DONE;
                        w_err_set   = 1'b1;
                    end
                end
                ST_DUMMY: begin
                    if (w_mode_bad) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_ccc_done_ok) begin
                        w_sel_ld = 1'b1;
                        if (w_sel_bad) begin
                            w_state_nxt = ST_DONE;
                            w_err_set   = 1'b1;
                        end else begin
                            w_state_nxt = ST_XFER;
                        end
                    end else if (w_wd_exp) begin
                        w_state_nxt = ST_DONE;
                        w_err_set   = 1'b1;
                    end
                end
                ST_XFER: begin
                    if (w_mode_bad) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_xfer_done_ok) begin
                        if (i_TOC) begin
                            w_state_nxt = ST_DONE;
                        end else if (i_CP) begin
                            w_state_nxt = ST_CCC;
                            w_rearm     = 1'b1;
                        end else begin
                            w_sel_ld = 1'b1;
                            if (w_sel_bad) begin
                                w_state_nxt = ST_DONE;
                                w_err_set   = 1'b1;
                            end else begin
                                w_state_nxt = ST_XFER;
                                w_rearm     = 1'b1;
                            end
                        end
                    end else if (w_wd_exp) begin
                        w_state_nxt = ST_DONE;
                        w_err_set   = 1'b1;
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
        w_wd_ld = is_phase(w_state_nxt) && ((w_state_nxt != r_state) || w_rearm);
    end

    // State and registered outputs, all derived from the decoded next state.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_ccc_en  <= 1'b0;
            r_xfer_en <= '0;
            r_addr    <= IDLE_ADDR;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_ccc_en  <= ((w_state_nxt == ST_CCC) || (w_state_nxt == ST_DUMMY)) && !w_rearm;
            r_xfer_en <= ((w_state_nxt == ST_XFER) && !w_rearm) ? w_xfer_oh : '0;
            r_addr    <= (w_state_nxt == ST_DUMMY) ? DUMMY_ADDR : IDLE_ADDR;
            r_done    <= (r_state == ST_DONE) && i_i3cengine_hdrengine_en;
            r_busy    <= (w_state_nxt != ST_IDLE);
            if (w_err_set) begin
                r_error <= 1'b1;
            end else if (w_err_clr) begin
                r_error <= 1'b0;
            end
        end
    end

    assign o_ccc_en                   = r_ccc_en;
    assign o_xfer_en                  = r_xfer_en;
    assign o_regf_addr_special        = r_addr;
    assign o_i3cengine_hdrengine_done = r_done;
    assign o_error                    = r_error;
    assign o_busy                     = r_busy;

endmodule

// File: tb/tb_hdr_engine_seq.sv
// Directed bench for hdr_engine_seq: completion pulses go through a scoreboard
// queue (expected cycle and error flag); enables/addresses are checked inline.
module tb_hdr_engine_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, cp, toc, ccc_done;
    logic [2:0] mode;
    logic [0:0] sel;
    logic [1:0] xfer_done;
    logic       ccc_en, done, err, busy;
    logic [1:0] xfer_en;
    logic [7:0] addr;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int   cyc;
        logic err;
    } exp_t;
    exp_t exp_q[$];

    hdr_engine_seq #(
        .NUM_MODES (2),
        .SEL_W     (1),
        .TMO_CYCLES(16'd16)
    ) dut (
        .i_sys_clk                 (clk),
        .i_sys_rst                 (rst),
        .i_i3cengine_hdrengine_en  (en),
        .i_CP                      (cp),
        .i_TOC                     (toc),
        .i_MODE                    (mode),
        .i_hdr_sel                 (sel),
        .i_ccc_done                (ccc_done),
        .i_xfer_done               (xfer_done),
        .o_ccc_en                  (ccc_en),
        .o_xfer_en                 (xfer_en),
        .o_regf_addr_special       (addr),
        .o_i3cengine_hdrengine_done(done),
        .o_error                   (err),
        .o_busy                    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_done(input logic e_err);
        exp_t e;
        e.cyc = cyc + 2;
        e.err = e_err;
        exp_q.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ccc_en"}, 32'(ccc_en), 32'd0);
        check({tag, "_xfer_en"}, 32'(xfer_en), 32'd0);
        check({tag, "_addr"}, 32'(addr), 32'h10);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Monitor: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: pulse at cycle %0d, none expected", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("done_error", 32'(err), 32'(e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; cp = 1'b0; toc = 1'b0; mode = 3'd6;
        sel = 1'b0; ccc_done = 1'b0; xfer_done = 2'b00;
        step(3);
        check_idle_outputs("reset");
        check("reset_error", 32'(err), 32'd0);
        rst = 1'b0;
        step(1);

        // CCC, exit on first done after 5 enabled cycles
        en = 1'b1; cp = 1'b1; toc = 1'b1;
        step(1);
        for (int i = 0; i < 4; i++) begin
            check("t1_ccc_en_hi", 32'(ccc_en), 32'd1);
            step(1);
        end
        check("t1_ccc_en_hi5", 32'(ccc_en), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        ccc_done = 1'b1;
        expect_done(1'b0);
        step(1);
        ccc_done = 1'b0;
        check("t1_ccc_en_lo", 32'(ccc_en), 32'd0);
        step(1);
        check("t1_error", 32'(err), 32'd0);
        en = 1'b0;
        step(1);

        // Normal transfer on sub-engine 1; foreign strobe ignored
        en = 1'b1; cp = 1'b0; sel = 1'b1; toc = 1'b1;
        step(1);
        check("t2_xfer_en", 32'(xfer_en), 32'h2);
        check("t2_ccc_en", 32'(ccc_en), 32'd0);
        xfer_done = 2'b01;
        step(1);
        xfer_done = 2'b00;
        check("t2_ignore_xfer_en", 32'(xfer_en), 32'h2);
        check("t2_ignore_busy", 32'(busy), 32'd1);
        step(1);
        xfer_done = 2'b10;
        expect_done(1'b0);
        step(1);
        xfer_done = 2'b00;
        check("t2_xfer_en_lo", 32'(xfer_en), 32'h0);
        step(1);
        en = 1'b0;
        step(1);

        // CCC restart into normal transfer goes through the dummy fetch
        en = 1'b1; cp = 1'b1; toc = 1'b0;
        step(1);
        check("t3_ccc_addr", 32'(addr), 32'h10);
        ccc_done = 1'b1; cp = 1'b0; sel = 1'b0;
        step(1);
        ccc_done = 1'b0;
        check("t3_dummy_addr", 32'(addr), 32'h84);
        check("t3_dummy_ccc_en", 32'(ccc_en), 32'd1);
        step(1);
        check("t3_dummy_addr_hold", 32'(addr), 32'h84);
        ccc_done = 1'b1; toc = 1'b1;
        step(1);
        ccc_done = 1'b0;
        check("t3_xfer_addr", 32'(addr), 32'h10);
        check("t3_xfer_en", 32'(xfer_en), 32'h1);
        check("t3_xfer_ccc_en", 32'(ccc_en), 32'd0);
        xfer_done = 2'b01;
        expect_done(1'b0);
        step(1);
        xfer_done = 2'b00;
        step(1);
        en = 1'b0;
        step(1);

        // CCC-to-CCC restart drops the enable for one cycle
        en = 1'b1; cp = 1'b1; toc = 1'b0;
        step(1);
        ccc_done = 1'b1;
        step(1);
        ccc_done = 1'b0;
        check("t7_rearm_gap", 32'(ccc_en), 32'd0);
        check("t7_rearm_busy", 32'(busy), 32'd1);
        step(1);
        check("t7_rearm_back", 32'(ccc_en), 32'd1);
        ccc_done = 1'b1; toc = 1'b1;
        expect_done(1'b0);
        step(1);
        ccc_done = 1'b0;
        step(1);
        en = 1'b0;
        step(1);

        // Mode change mid-transfer aborts without error
        en = 1'b1; cp = 1'b0; sel = 1'b0; toc = 1'b1;
        step(1);
        check("t4_xfer_en", 32'(xfer_en), 32'h1);
        mode = 3'd3;
        expect_done(1'b0);
        step(1);
        mode = 3'd6;
        check("t4_abort_xfer_en", 32'(xfer_en), 32'h0);
        step(1);
        check("t4_error", 32'(err), 32'd0);
        en = 1'b0;
        step(1);

        // Watchdog: 16 phase cycles without done, then error
        en = 1'b1; cp = 1'b1; toc = 1'b1;
        exp_q.push_back('{cyc + 18, 1'b1});
        step(1);
        for (int i = 0; i < 16; i++) begin
            check("t5_ccc_en_hold", 32'(ccc_en), 32'd1);
            step(1);
        end
        check("t5_tmo_ccc_en", 32'(ccc_en), 32'd0);
        check("t5_tmo_error", 32'(err), 32'd1);
        step(1);
        en = 1'b0;
        step(1);
        check("t5_error_sticky", 32'(err), 32'd1);
        en = 1'b1; cp = 1'b0; sel = 1'b1;
        step(1);
        check("t5_error_clear", 32'(err), 32'd0);
        check("t5_xfer_en", 32'(xfer_en), 32'h2);

        // Reset mid-transfer
        rst = 1'b1;
        step(1);
        check_idle_outputs("t6_rst");
        rst = 1'b0; en = 1'b0;
        step(2);

        // Enable drop mid-CCC
        en = 1'b1; cp = 1'b1; toc = 1'b1;
        step(1);
        check("t6_ccc_en", 32'(ccc_en), 32'd1);
        step(1);
        en = 1'b0;
        step(1);
        check_idle_outputs("t6_drop");
        step(4);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hdr_engine_seq.md
Name: hdr_engine_seq

Overview:
- Parametrised HDR-mode sequencer, the successor to the single-target HDR engine.
- Sits between the I3C engine and NUM_MODES HDR sub-engines (DDR, BT, ...) plus the CCC engine.
- Runs CCC and normal transactions back-to-back under TOC restart/exit control, inserting a dummy-CCC fetch where the restart switches from CCC to a normal transfer.
- Adds a per-phase watchdog, mode-change abort and an error flag.

Parameters:
- NUM_MODES, 2, number of HDR transfer sub-engines (index 0 = DDR).
- SEL_W, 1, width of i_hdr_sel; must satisfy SEL_W >= clog2(NUM_MODES), min 1.
- ADDR_W, 8, width of o_regf_addr_special.
- IDLE_ADDR, 8'h10, register-file address driven when not fetching a dummy.
- DUMMY_ADDR, 8'h84, special register-file address holding the dummy CCC value.
- HDR_MODE_CODE, 3'd6, i_MODE value meaning "HDR active".
- TMO_W, 16, watchdog counter width.
- TMO_CYCLES, 16'd50000, cycles allowed per CCC/XFER phase before abort.

Ports:
- i_sys_clk  in  1  system clock.
- i_sys_rst  in  1  reset, synchronous, active-high.
- i_i3cengine_hdrengine_en  in  1  level enable from the I3C engine.
- i_CP  in  1  command present: 1 = CCC, 0 = normal transfer; sampled at phase start/end.
- i_TOC  in  1  term of completion: 1 = exit, 0 = restart; sampled with the done strobe.
- i_MODE  in  3  current bus mode.
- i_hdr_sel  in  SEL_W  target sub-engine index; latched on leaving IDLE and on each restart into XFER.
- i_ccc_done  in  1  one-cycle done strobe from the CCC engine.
- i_xfer_done  in  NUM_MODES  done strobes, one per sub-engine.
- o_ccc_en  out  1  CCC engine enable.
- o_xfer_en  out  NUM_MODES  one-hot sub-engine enable.
- o_regf_addr_special  out  ADDR_W  register-file special address.
- o_i3cengine_hdrengine_done  out  1  one-cycle completion pulse.
- o_error  out  1  sticky: timeout or invalid selection; cleared on the next IDLE exit.
- o_busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (synchronous, i_sys_rst=1 at the clock edge) values:
  - state=IDLE; o_ccc_en=0; o_xfer_en=0; o_regf_addr_special=IDLE_ADDR.
  - done=0; o_error=0; o_busy=0; watchdog=0.
  - Reset mid-operation drops all enables on the same edge.
- States: IDLE, CCC, DUMMY, XFER, DONE. All outputs are registered.
- Enable drop: i_i3cengine_hdrengine_en=0 in any state → IDLE next cycle, enables cleared, no done pulse.
- IDLE, enable=1:
  - i_CP=1 → CCC.
  - i_CP=0 → XFER with sel latched.
  - Latched sel >= NUM_MODES → DONE with o_error=1.
  - o_error is cleared on this transition.
- CCC:
  - o_ccc_en=1.
  - On i_ccc_done with i_TOC=1 → DONE.
  - On i_ccc_done with i_TOC=0 and i_CP=1 → stay in CCC; o_ccc_en deasserts for one cycle to re-arm.
  - On i_ccc_done with i_TOC=0 and i_CP=0 → DUMMY.
- DUMMY:
  - o_regf_addr_special=DUMMY_ADDR and o_ccc_en=1 until i_ccc_done.
  - Then address returns to IDLE_ADDR, sel is latched, and the FSM goes to XFER (or DONE+error if sel is invalid).
- XFER:
  - o_xfer_en[sel]=1; all other bits 0.
  - Only i_xfer_done[sel] is honoured; strobes on other bits are ignored.
  - On done with i_TOC=1 → DONE.
  - On done with i_TOC=0 → re-arm (enable low one cycle) into CCC if i_CP=1, or into XFER with sel relatched.
- DONE:
  - All enables 0; o_i3cengine_hdrengine_done=1 for exactly one cycle.
  - → IDLE next cycle, even if enable is still high.
  - A new run starts only after IDLE is seen.
- Mode abort: i_MODE != HDR_MODE_CODE in CCC, DUMMY or XFER → DONE next cycle, o_error unchanged.
- Watchdog:
  - Counts cycles in CCC, DUMMY and XFER; clears on every phase entry.
  - Reaching TMO_CYCLES-1 → DONE with o_error=1.
  - The counter saturates and never wraps.
- Priority when events coincide in one cycle: reset > enable drop > mode abort > done strobe > timeout. Done on the timeout cycle counts as success.
- Latency: enable-to-engine enable = 1 cycle; done strobe to completion pulse = 2 cycles (strobe→DONE, DONE→pulse visible).

Decomposition:
- Package hdr_pkg holds:
  - the state enum (IDLE, CCC, DUMMY, XFER, DONE);
  - the HDR_MODE_CODE constant;
  - the DUMMY_ADDR and IDLE_ADDR defaults.
- One natural sub-module: hdr_watchdog (loadable saturating counter with clear, enable and expiry flag), reusable by the sub-engines.

Test Plan:
- i_CP=1, i_TOC=1, ccc_done after 5 cycles → o_ccc_en high 5 cycles, done pulse 2 cycles after strobe, o_error=0.
- i_CP=0, sel=1, i_TOC=1 → o_xfer_en=2'b10 only. A strobe on i_xfer_done[0] is ignored; i_xfer_done[1] produces the done pulse.
- CCC with i_TOC=0 and i_CP switched to 0 → o_regf_addr_special=8'h84 during DUMMY; after ccc_done, address returns to 8'h10 and o_xfer_en=2'b01 (sel=0).
- i_MODE changes 6→3 mid-XFER → enables drop, done pulse fires, o_error=0.
- TMO_CYCLES=16 with no done strobe → DONE at cycle 16 of the phase, o_error=1; o_error clears on the next run start.
- Reset asserted mid-XFER, and enable dropped mid-CCC → all outputs return to reset values within one edge, no done pulse.
